// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round engine.
// Holds the P table, FSM states and round-index width.
package des_pkg;

  localparam int RN_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  // Output DES bit i takes input DES bit P_TAB[i].
  localparam int P_TAB [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_pperm.sv
// DES P permutation, purely combinational.
// DES bit k of a 32-bit word lives at vector index 33-k.
module des_pperm
  import des_pkg::*;
(
  input  logic [32:1] din,
  output logic [32:1] dout
);

  for (genvar i = 1; i <= 32; i++) begin : g_p
    localparam int SRC = 33 - P_TAB[i];
    assign dout[33-i] = din[SRC];
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES Feistel round engine between IP and FP.
// Drives R and round index out, folds the S-box result back in.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS    = 16,
  parameter int SBOX_WAIT = 0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [64:1]     IN_DATA,
  output logic [32:1]     ROUND_R,
  output logic [RN_W-1:0] ROUND_NUM,
  input  logic [32:1]     S_OUTPUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [64:1]     OUT_DATA,
  output logic            BUSY
);

  localparam logic [RN_W-1:0] LAST =
    RN_W'(ROUNDS - 1);
  localparam logic [2:0] WAIT_LD =
    3'(SBOX_WAIT);

  state_t          state;
  logic [32:1]     l_q;
  logic [32:1]     r_q;
  logic [32:1]     p_out;
  logic [2:0]      wait_q;
  logic [RN_W-1:0] rn_q;
  logic            in_rdy_q;
  logic            out_vld_q;
  logic            busy_q;

  des_pperm u_pperm (
    .din  (S_OUTPUT),
    .dout (p_out)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      wait_q    <= '0;
      rn_q      <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID && in_rdy_q) begin
            l_q      <= IN_DATA[64:33];
            r_q      <= IN_DATA[32:1];
            rn_q     <= '0;
            wait_q   <= WAIT_LD;
            state    <= ROUND;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ROUND: begin
          // S_OUTPUT is only looked at once the wait expires.
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end else begin
            l_q <= r_q;
            r_q <= l_q ^ p_out;
            if (rn_q == LAST) begin
              state     <= DONE;
              out_vld_q <= 1'b1;
            end else begin
              rn_q   <= rn_q + 1'b1;
              wait_q <= WAIT_LD;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = in_rdy_q;
  assign OUT_VALID = out_vld_q;
  assign BUSY      = busy_q;
  assign ROUND_R   = r_q;
  assign ROUND_NUM = rn_q;
  assign OUT_DATA  = {r_q, l_q};

endmodule
